// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t : fetch controller states
//   PC_*          : sel_pc encodings for the next-PC mux
//   NOP_WORD      : instruction register value after reset
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_INC    = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] PC_RESET  = 2'b11;

    localparam logic [31:0] NOP_WORD = 32'h0;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (pc <= RESET_VEC)
//   enable         : FSM gate; when low the pc cannot change
//   load_pc        : update pc this cycle according to sel_pc
//   sel_pc         : hold / pc+1 / branch_target / RESET_VEC
//   branch_target  : redirect word address, used as-is
//   pc             : current program counter
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [10:0] RESET_VEC = 11'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load_pc,
    input  logic [1:0]  sel_pc,
    input  logic [10:0] branch_target,
    output logic [10:0] pc
);

    logic [10:0] pc_next;

    // 11-bit add wraps 2047 -> 0 on its own.
    always_comb begin
        pc_next = pc;
        unique case (sel_pc)
            PC_HOLD:   pc_next = pc;
            PC_INC:    pc_next = pc + 11'd1;
            PC_BRANCH: pc_next = branch_target;
            PC_RESET:  pc_next = RESET_VEC;
            default:   pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VEC;
        end else if (enable && load_pc) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, issues instruction-RAM reads and
// captures the returned word after RAM_LAT cycles.
//
//   state  | meaning
//   IDLE   | no fetch in flight; pc may be loaded, fetch may start
//   WAIT   | fetch in flight; counting RAM latency, pc stable
//   HALTED | core stopped; everything frozen until reset
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   load_pc/sel_pc : pc update request and next-pc select
//   branch_target  : redirect word address
//   fetch_req      : start a fetch at the current pc
//   halt           : stop the core (after any in-flight fetch)
//   ram_rd_data1   : instruction-RAM read data
//   ram_addr1      : instruction-RAM read address (= pc)
//   ir, pc         : instruction register, program counter
//   busy           : fetch in flight
//   fetch_done     : one-cycle pulse after ir was loaded
//   halted         : core halted
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [10:0] RESET_VEC = 11'd0,
    parameter int          RAM_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_pc,
    input  logic [1:0]  sel_pc,
    input  logic [10:0] branch_target,
    input  logic        fetch_req,
    input  logic        halt,
    input  logic [31:0] ram_rd_data1,
    output logic [10:0] ram_addr1,
    output logic [31:0] ir,
    output logic [10:0] pc,
    output logic        busy,
    output logic        fetch_done,
    output logic        halted
);

    // Counter runs 0..RAM_LAT-1; RAM_LAT is limited to 1..4.
    localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

    fetch_state_t state;
    logic [1:0]   lat_cnt;
    logic         halt_pend;
    logic         pc_en;
    logic         redirect;

    assign redirect  = load_pc && (sel_pc != PC_HOLD);
    assign ram_addr1 = pc;

    // In WAIT only a real redirect may touch pc; halt in IDLE blocks a
    // simultaneous load since halt has priority.
    always_comb begin
        pc_en = 1'b0;
        unique case (state)
            IDLE:    pc_en = !halt;
            WAIT:    pc_en = redirect;
            HALTED:  pc_en = 1'b0;
            default: pc_en = 1'b0;
        endcase
    end

    fetch_pc_reg #(
        .RESET_VEC (RESET_VEC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (pc_en),
        .load_pc       (load_pc),
        .sel_pc        (sel_pc),
        .branch_target (branch_target),
        .pc            (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= 2'd0;
            halt_pend  <= 1'b0;
            ir         <= NOP_WORD;
            busy       <= 1'b0;
            fetch_done <= 1'b0;
            halted     <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (fetch_req && !load_pc) begin
                        state     <= WAIT;
                        lat_cnt   <= 2'd0;
                        busy      <= 1'b1;
                        halt_pend <= 1'b0;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        // Abort: returning data is dropped, no done pulse.
                        lat_cnt   <= 2'd0;
                        busy      <= 1'b0;
                        halt_pend <= 1'b0;
                        if (halt_pend || halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (lat_cnt == LAT_LAST) begin
                        ir         <= ram_rd_data1;
                        fetch_done <= 1'b1;
                        busy       <= 1'b0;
                        lat_cnt    <= 2'd0;
                        halt_pend  <= 1'b0;
                        if (halt_pend || halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                        if (halt) begin
                            halt_pend <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: RAM_LAT = 1
    logic        a_rst_n, a_load, a_freq, a_halt;
    logic [1:0]  a_sel;
    logic [10:0] a_bt;
    logic [31:0] a_data;
    logic [10:0] a_addr, a_pc;
    logic [31:0] a_ir;
    logic        a_busy, a_fd, a_halted;

    // Instance B: RAM_LAT = 3
    logic        b_rst_n, b_load, b_freq, b_halt;
    logic [1:0]  b_sel;
    logic [10:0] b_bt;
    logic [31:0] b_data;
    logic [10:0] b_addr, b_pc;
    logic [31:0] b_ir;
    logic        b_busy, b_fd, b_halted;

    instr_fetch_unit #(.RESET_VEC(11'd0), .RAM_LAT(1)) ua (
        .clk(clk), .rst_n(a_rst_n), .load_pc(a_load), .sel_pc(a_sel),
        .branch_target(a_bt), .fetch_req(a_freq), .halt(a_halt),
        .ram_rd_data1(a_data), .ram_addr1(a_addr), .ir(a_ir), .pc(a_pc),
        .busy(a_busy), .fetch_done(a_fd), .halted(a_halted)
    );

    instr_fetch_unit #(.RESET_VEC(11'd0), .RAM_LAT(3)) ub (
        .clk(clk), .rst_n(b_rst_n), .load_pc(b_load), .sel_pc(b_sel),
        .branch_target(b_bt), .fetch_req(b_freq), .halt(b_halt),
        .ram_rd_data1(b_data), .ram_addr1(b_addr), .ir(b_ir), .pc(b_pc),
        .busy(b_busy), .fetch_done(b_fd), .halted(b_halted)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        a_rst_n = 0; a_load = 0; a_sel = 2'b00; a_bt = 11'd0; a_freq = 0; a_halt = 0; a_data = 32'h0;
        b_rst_n = 0; b_load = 0; b_sel = 2'b00; b_bt = 11'd0; b_freq = 0; b_halt = 0; b_data = 32'h0;
        #2;
        chk("rst_pc",     32'(a_pc), 32'h0);
        chk("rst_addr",   32'(a_addr), 32'h0);
        chk("rst_ir",     a_ir, 32'h0);
        chk("rst_busy",   32'(a_busy), 32'h0);
        chk("rst_done",   32'(a_fd), 32'h0);
        chk("rst_halted", 32'(a_halted), 32'h0);
        step();
        a_rst_n = 1; b_rst_n = 1;
        step();

        // 1: pc+1 then fetch with RAM_LAT=1
        a_load = 1; a_sel = 2'b01;
        step();
        a_load = 0; a_sel = 2'b00;
        chk("t1_pc1", 32'(a_pc), 32'h1);
        a_freq = 1; a_data = 32'hE3A01005;
        step();
        a_freq = 0;
        chk("t1_busy_e0", 32'(a_busy), 32'h1);
        chk("t1_addr",    32'(a_addr), 32'h1);
        chk("t1_ir_e0",   a_ir, 32'h0);
        chk("t1_done_e0", 32'(a_fd), 32'h0);
        step();
        chk("t1_ir_e1",   a_ir, 32'hE3A01005);
        chk("t1_done_e1", 32'(a_fd), 32'h1);
        chk("t1_busy_e1", 32'(a_busy), 32'h0);
        step();
        chk("t1_done_e2", 32'(a_fd), 32'h0);

        // 3: wrap, branch, reset vector
        a_load = 1; a_sel = 2'b10; a_bt = 11'h7FF;
        step();
        chk("t3_pc7ff", 32'(a_pc), 32'h7FF);
        a_sel = 2'b01;
        step();
        chk("t3_wrap", 32'(a_pc), 32'h0);
        a_sel = 2'b10; a_bt = 11'h123;
        step();
        chk("t3_branch", 32'(a_pc), 32'h123);
        a_sel = 2'b00;
        step();
        chk("t3_hold", 32'(a_pc), 32'h123);
        a_sel = 2'b11;
        step();
        chk("t3_rstvec", 32'(a_pc), 32'h0);

        // 5a: fetch_req with load_pc -> load wins
        a_sel = 2'b01; a_freq = 1; a_data = 32'h0BADF00D;
        step();
        a_load = 0; a_sel = 2'b00; a_freq = 0;
        chk("t5_pc",   32'(a_pc), 32'h1);
        chk("t5_busy", 32'(a_busy), 32'h0);
        step();
        chk("t5_done", 32'(a_fd), 32'h0);
        chk("t5_ir",   a_ir, 32'hE3A01005);

        // 6c: reset mid-fetch
        a_freq = 1; a_data = 32'h12345678;
        step();
        a_freq = 0;
        chk("t6r_busy_before", 32'(a_busy), 32'h1);
        #2 a_rst_n = 0;
        #1;
        chk("t6r_busy", 32'(a_busy), 32'h0);
        chk("t6r_pc",   32'(a_pc), 32'h0);
        chk("t6r_ir",   a_ir, 32'h0);
        step();
        chk("t6r_done", 32'(a_fd), 32'h0);
        chk("t6r_ir2",  a_ir, 32'h0);
        a_rst_n = 1;

        // 2: RAM_LAT=3 fetch at pc=5
        b_load = 1; b_sel = 2'b10; b_bt = 11'd5;
        step();
        b_load = 0; b_sel = 2'b00;
        b_freq = 1; b_data = 32'hAABBCCDD;
        step();
        b_freq = 0;
        chk("t2_busy_e0", 32'(b_busy), 32'h1);
        chk("t2_addr_e0", 32'(b_addr), 32'h5);
        step();
        chk("t2_busy_e1", 32'(b_busy), 32'h1);
        chk("t2_ir_e1",   b_ir, 32'h0);
        // load_pc with hold in WAIT is ignored
        b_load = 1; b_sel = 2'b00;
        step();
        b_load = 0;
        chk("t2_busy_e2", 32'(b_busy), 32'h1);
        chk("t2_ir_e2",   b_ir, 32'h0);
        chk("t2_addr_e2", 32'(b_addr), 32'h5);
        step();
        chk("t2_ir_e3",   b_ir, 32'hAABBCCDD);
        chk("t2_busy_e3", 32'(b_busy), 32'h0);
        chk("t2_done_e3", 32'(b_fd), 32'h1);
        step();
        chk("t2_done_e4", 32'(b_fd), 32'h0);

        // 4: redirect aborts the fetch
        b_freq = 1; b_data = 32'h11111111;
        step();
        b_freq = 0;
        step();
        b_load = 1; b_sel = 2'b10; b_bt = 11'h040;
        step();
        b_load = 0; b_sel = 2'b00;
        chk("t4_pc",   32'(b_pc), 32'h040);
        chk("t4_busy", 32'(b_busy), 32'h0);
        chk("t4_ir",   b_ir, 32'hAABBCCDD);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (b_fd) n++;
            step();
        end
        chk("t4_no_done", 32'(n), 32'h0);
        chk("t4_ir_after", b_ir, 32'hAABBCCDD);

        // 5b: fetch_req held during WAIT gives one fetch
        b_freq = 1; b_data = 32'h22222222;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 2) b_freq = 0;
            if (b_fd) n++;
        end
        chk("t5b_one_done", 32'(n), 32'h1);
        chk("t5b_ir",       b_ir, 32'h22222222);
        chk("t5b_addr",     32'(b_addr), 32'h040);

        // 6: halt in WAIT
        b_freq = 1; b_data = 32'h33333333;
        step();
        b_freq = 0; b_halt = 1;
        step();
        b_halt = 0;
        chk("t6_halted_mid", 32'(b_halted), 32'h0);
        step();
        step();
        chk("t6_done",   32'(b_fd), 32'h1);
        chk("t6_ir",     b_ir, 32'h33333333);
        chk("t6_halted", 32'(b_halted), 32'h1);
        b_load = 1; b_sel = 2'b10; b_bt = 11'h3FF; b_freq = 1; b_data = 32'h44444444;
        step(); step(); step(); step();
        b_load = 0; b_sel = 2'b00; b_freq = 0;
        chk("t6_pc_frozen", 32'(b_pc), 32'h040);
        chk("t6_ir_frozen", b_ir, 32'h33333333);
        chk("t6_busy",      32'(b_busy), 32'h0);
        chk("t6_done_off",  32'(b_fd), 32'h0);
        chk("t6_still",     32'(b_halted), 32'h1);
        b_rst_n = 0;
        #1;
        chk("t6_rst_halted", 32'(b_halted), 32'h0);
        chk("t6_rst_pc",     32'(b_pc), 32'h0);
        step();
        b_rst_n = 1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
